// File: rtl/lab4_sys_mem_net_rr.sv
// Four-port round-robin memory network: tags requests with the source core ID and steers responses back by that tag.
// Optional per-port accepted-request counters are enabled with `define LAB4_SYS_MEM_NET_STATS_EN.
package lab4_mem_msgs_pkg;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [31:0]  addr;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_req_16B_t;

    typedef struct packed {
        logic [2:0]   msg_type;
        logic [7:0]   opaque;
        logic [1:0]   test;
        logic [3:0]   len;
        logic [127:0] data;
    } mem_resp_16B_t;

endpackage

module lab4_sys_mem_net_rr
    import lab4_mem_msgs_pkg::*;
#(
    parameter int p_num_ports      = 4,
    parameter int p_req_fifo_depth = 2
) (
    input  logic                   clk,
    input  logic                   reset,

    input  mem_req_16B_t           cache2net_reqstream_msg [p_num_ports],
    input  logic [p_num_ports-1:0] cache2net_reqstream_val,
    output logic [p_num_ports-1:0] cache2net_reqstream_rdy,

    output mem_resp_16B_t          cache2net_respstream_msg [p_num_ports],
    output logic [p_num_ports-1:0] cache2net_respstream_val,
    input  logic [p_num_ports-1:0] cache2net_respstream_rdy,

    output mem_req_16B_t           net2mem_reqstream_msg,
    output logic                   net2mem_reqstream_val,
    input  logic                   net2mem_reqstream_rdy,

    input  mem_resp_16B_t          net2mem_respstream_msg,
    input  logic                   net2mem_respstream_val,
    output logic                   net2mem_respstream_rdy
`ifdef LAB4_SYS_MEM_NET_STATS_EN
    ,
    output logic [31:0]            req_count [p_num_ports]
`endif
);

    localparam logic [1:0] c_fifo_full = 2'(p_req_fifo_depth);

    // Holds every ready low until the first clock edge after reset release.
    logic          running_reg;
    logic [1:0]    ptr_reg;

    mem_req_16B_t  fifo_mem_reg [p_req_fifo_depth];
    logic [0:0]    head_reg;
    logic [0:0]    tail_reg;
    logic [1:0]    count_reg;
    logic [1:0]    count_next;

    mem_resp_16B_t resp_msg_reg;
    logic [1:0]    dest_reg;
    logic          full_reg;

    logic          grant_val;
    logic [1:0]    grant_idx;
    logic [1:0]    cand;
    logic          can_accept;
    logic          enq;
    logic          deq;
    mem_req_16B_t  enq_msg;
    mem_resp_16B_t resp_out;
    logic          resp_accept;
    logic          resp_deliver;

    // Cores promise opaque < 64, so the top two bits are overwritten by the tag.
    logic [p_num_ports-1:0] unused_opaque_hi;

    always_comb begin
        grant_val = 1'b0;
        grant_idx = ptr_reg;
        cand      = '0;
        for (int i = 0; i < p_num_ports; i++) begin
            cand = ptr_reg + 2'(i);
            if (!grant_val && cache2net_reqstream_val[cand]) begin
                grant_val = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign can_accept = running_reg && (count_reg != c_fifo_full);
    assign enq        = can_accept && grant_val;
    assign deq        = (count_reg != 2'd0) && net2mem_reqstream_rdy;

    always_comb begin
        enq_msg        = cache2net_reqstream_msg[grant_idx];
        enq_msg.opaque = {grant_idx, cache2net_reqstream_msg[grant_idx].opaque[5:0]};
    end

    always_comb begin
        count_next = count_reg;
        case ({enq, deq})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    assign net2mem_reqstream_val = (count_reg != 2'd0);
    assign net2mem_reqstream_msg = fifo_mem_reg[head_reg];

    assign resp_deliver           = full_reg && cache2net_respstream_rdy[dest_reg];
    assign net2mem_respstream_rdy = running_reg && (!full_reg || cache2net_respstream_rdy[dest_reg]);
    assign resp_accept            = net2mem_respstream_val && net2mem_respstream_rdy;

    always_comb begin
        resp_out             = resp_msg_reg;
        resp_out.opaque[7:6] = 2'b00;
    end

    generate
        for (genvar gi = 0; gi < p_num_ports; gi++) begin : g_port
            assign cache2net_reqstream_rdy[gi]  = enq && (grant_idx == 2'(gi));
            assign cache2net_respstream_val[gi] = full_reg && (dest_reg == 2'(gi));
            assign cache2net_respstream_msg[gi] = resp_out;
            assign unused_opaque_hi[gi]         = ^cache2net_reqstream_msg[gi].opaque[7:6];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            running_reg <= 1'b0;
            ptr_reg     <= 2'd0;
            head_reg    <= 1'b0;
            tail_reg    <= 1'b0;
            count_reg   <= 2'd0;
            dest_reg    <= 2'd0;
            full_reg    <= 1'b0;
        end else begin
            running_reg <= 1'b1;
            count_reg   <= count_next;
            if (enq) begin
                ptr_reg  <= grant_idx + 2'd1;
                tail_reg <= tail_reg + 1'b1;
            end
            if (deq) begin
                head_reg <= head_reg + 1'b1;
            end
            // A same-cycle refill keeps the register full for back-to-back responses.
            if (resp_accept) begin
                dest_reg <= net2mem_respstream_msg.opaque[7:6];
                full_reg <= 1'b1;
            end else if (resp_deliver) begin
                full_reg <= 1'b0;
            end
        end
    end

    // Payload storage carries no reset; validity lives in count_reg and full_reg.
    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_mem_reg[tail_reg] <= enq_msg;
        end
        if (resp_accept) begin
            resp_msg_reg <= net2mem_respstream_msg;
        end
    end

`ifdef LAB4_SYS_MEM_NET_STATS_EN
    logic [31:0] req_count_reg [p_num_ports];

    generate
        for (genvar gi = 0; gi < p_num_ports; gi++) begin : g_stats
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    req_count_reg[gi] <= 32'd0;
                end else if (enq && (grant_idx == 2'(gi))) begin
                    req_count_reg[gi] <= req_count_reg[gi] + 32'd1;
                end
            end
            assign req_count[gi] = req_count_reg[gi];
        end
    endgenerate
`endif

endmodule

// File: tb/tb_lab4_sys_mem_net_rr.sv
// Directed bench for lab4_sys_mem_net_rr: stimulus pushes expected memory requests and cache responses
// to scoreboard queues; a negedge monitor pops and compares them as handshakes occur.
module tb_lab4_sys_mem_net_rr;
    import lab4_mem_msgs_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    mem_req_16B_t  c_req_msg [4];
    logic [3:0]    c_req_val;
    logic [3:0]    c_req_rdy;
    mem_resp_16B_t c_resp_msg [4];
    logic [3:0]    c_resp_val;
    logic [3:0]    c_resp_rdy;
    mem_req_16B_t  m_req_msg;
    logic          m_req_val;
    logic          m_req_rdy;
    mem_resp_16B_t m_resp_msg;
    logic          m_resp_val;
    logic          m_resp_rdy;
`ifdef LAB4_SYS_MEM_NET_STATS_EN
    logic [31:0]   req_count [4];
`endif

    lab4_sys_mem_net_rr dut (
        .clk                      (clk),
        .reset                    (reset),
        .cache2net_reqstream_msg  (c_req_msg),
        .cache2net_reqstream_val  (c_req_val),
        .cache2net_reqstream_rdy  (c_req_rdy),
        .cache2net_respstream_msg (c_resp_msg),
        .cache2net_respstream_val (c_resp_val),
        .cache2net_respstream_rdy (c_resp_rdy),
        .net2mem_reqstream_msg    (m_req_msg),
        .net2mem_reqstream_val    (m_req_val),
        .net2mem_reqstream_rdy    (m_req_rdy),
        .net2mem_respstream_msg   (m_resp_msg),
        .net2mem_respstream_val   (m_resp_val),
        .net2mem_respstream_rdy   (m_resp_rdy)
`ifdef LAB4_SYS_MEM_NET_STATS_EN
        ,
        .req_count                (req_count)
`endif
    );

    typedef struct {
        int            port;
        mem_resp_16B_t msg;
    } resp_exp_t;

    mem_req_16B_t req_q  [$];
    resp_exp_t    resp_q [$];
    int n_checks = 0;
    int n_errors = 0;
    int model_ptr = 0;

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mem_req_16B_t mk_req(input logic [31:0] addr, input logic [7:0] opq);
        mem_req_16B_t r;
        r.msg_type = 3'd0;
        r.opaque   = opq;
        r.addr     = addr;
        r.len      = 4'd0;
        r.data     = {4{addr ^ 32'h5a5a_0000}};
        return r;
    endfunction

    function automatic mem_req_16B_t tag_req(input mem_req_16B_t r, input int g);
        mem_req_16B_t t;
        t        = r;
        t.opaque = {2'(g), r.opaque[5:0]};
        return t;
    endfunction

    function automatic mem_resp_16B_t mk_resp(input logic [7:0] opq, input logic [31:0] d);
        mem_resp_16B_t r;
        r.msg_type = 3'd0;
        r.opaque   = opq;
        r.test     = 2'd0;
        r.len      = 4'd0;
        r.data     = {4{d}};
        return r;
    endfunction

    function automatic int rr_pick(input int ptr, input logic [3:0] val);
        for (int i = 0; i < 4; i++) begin
            if (val[(ptr + i) % 4]) return (ptr + i) % 4;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input int p, input logic [31:0] addr, input logic [7:0] opq);
        c_req_val    = 4'b0000;
        c_req_val[p] = 1'b1;
        c_req_msg[p] = mk_req(addr, opq);
        #1;
        check("send_grant", 192'(c_req_rdy), 192'(1 << p));
        req_q.push_back(tag_req(c_req_msg[p], p));
        model_ptr = (p + 1) % 4;
        tick();
        c_req_val = 4'b0000;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40 && (req_q.size() != 0 || resp_q.size() != 0); i++) tick();
        check({tag, "_req_q_empty"}, 192'(req_q.size()), 192'(0));
        check({tag, "_resp_q_empty"}, 192'(resp_q.size()), 192'(0));
    endtask

    // Handshake inputs only change just after posedge, so negedge sees what the next edge will transfer.
    always @(negedge clk) begin
        if (reset) begin
            if (m_req_val && m_req_rdy) begin
                mem_req_16B_t e;
                check("mem_req_expected", 192'(req_q.size() != 0), 192'(1));
                if (req_q.size() != 0) begin
                    e = req_q.pop_front();
                    $display("%0t mem req  opaque=%02h addr=%08h", $time, m_req_msg.opaque, m_req_msg.addr);
                    check("mem_req_msg", 192'(m_req_msg), 192'(e));
                end
            end
            if (c_resp_val != 4'b0000) begin
                check("resp_val_onehot", 192'($onehot0(c_resp_val)), 192'(1));
            end
            for (int d = 0; d < 4; d++) begin
                if (c_resp_val[d] && c_resp_rdy[d]) begin
                    resp_exp_t r;
                    check("resp_expected", 192'(resp_q.size() != 0), 192'(1));
                    if (resp_q.size() != 0) begin
                        r = resp_q.pop_front();
                        $display("%0t resp port=%0d opaque=%02h", $time, d, c_resp_msg[d].opaque);
                        check("resp_port", 192'(d), 192'(r.port));
                        check("resp_msg", 192'(c_resp_msg[d]), 192'(r.msg));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        reset      = 1'b0;
        c_req_val  = 4'hF;
        c_resp_rdy = 4'hF;
        m_req_rdy  = 1'b1;
        m_resp_val = 1'b0;
        m_resp_msg = mk_resp(8'h00, 32'h0);
        for (int p = 0; p < 4; p++) c_req_msg[p] = mk_req(32'h0, 8'h00);

        // Reset state, with all requesters valid to prove ready stays low
        repeat (3) tick();
        check("rst_req_rdy", 192'(c_req_rdy), 192'(0));
        check("rst_mem_req_val", 192'(m_req_val), 192'(0));
        check("rst_resp_val", 192'(c_resp_val), 192'(0));
        check("rst_mem_resp_rdy", 192'(m_resp_rdy), 192'(0));
        c_req_val = 4'h0;
        reset     = 1'b1;
        tick();
        check("post_rst_mem_resp_rdy", 192'(m_resp_rdy), 192'(1));
        check("post_rst_mem_req_val", 192'(m_req_val), 192'(0));

        // Round robin, all ports valid, memory always ready
        for (int i = 0; i < 8; i++) begin
            for (int p = 0; p < 4; p++) c_req_msg[p] = mk_req(32'h2000 + 32'(i * 64 + p * 4), 8'(i * 4 + p));
            c_req_val = 4'hF;
            #1;
            g = model_ptr;
            check("rr_grant", 192'(c_req_rdy), 192'(1 << g));
            req_q.push_back(tag_req(c_req_msg[g], g));
            model_ptr = (g + 1) % 4;
            tick();
        end
        c_req_val = 4'h0;
        drain("rr");

        // Single request from port 2
        begin
            mem_req_16B_t e;
            c_req_msg[2] = mk_req(32'h1000, 8'h05);
            c_req_val    = 4'b0100;
            #1;
            check("single_grant", 192'(c_req_rdy), 192'(4'b0100));
            check("single_no_bypass", 192'(m_req_val), 192'(0));
            e        = c_req_msg[2];
            e.opaque = 8'h85;
            req_q.push_back(e);
            model_ptr = 3;
            tick();
            c_req_val = 4'h0;
            #1;
            check("single_visible", 192'(m_req_val), 192'(1));
            tick();
            check("single_drained", 192'(m_req_val), 192'(0));
        end
        m_resp_msg = mk_resp(8'h85, 32'hCAFE_0002);
        m_resp_val = 1'b1;
        #1;
        check("single_resp_accept", 192'(m_resp_rdy), 192'(1));
        resp_q.push_back('{port: 2, msg: mk_resp(8'h05, 32'hCAFE_0002)});
        tick();
        m_resp_val = 1'b0;
        #1;
        check("single_resp_val", 192'(c_resp_val), 192'(4'b0100));
        tick();
        check("single_resp_done", 192'(c_resp_val), 192'(0));
        drain("single");

        // Full FIFO with memory stalled
        m_req_rdy    = 1'b0;
        c_req_msg[0] = mk_req(32'h3000, 8'h11);
        c_req_msg[1] = mk_req(32'h3100, 8'h22);
        c_req_val    = 4'b0011;
        for (int k = 0; k < 2; k++) begin
            #1;
            g = rr_pick(model_ptr, c_req_val);
            check("full_grant", 192'(c_req_rdy), 192'(1 << g));
            check("full_grant_order", 192'(g), 192'(k));
            req_q.push_back(tag_req(c_req_msg[g], g));
            model_ptr = (g + 1) % 4;
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            #1;
            check("full_no_grant", 192'(c_req_rdy), 192'(0));
            check("full_mem_val", 192'(m_req_val), 192'(1));
            tick();
        end
        c_req_val = 4'h0;
        m_req_rdy = 1'b1;
        drain("full");

        // Response backpressure: port 3 stalled, port 1 queued behind it
        c_resp_rdy = 4'b0111;
        m_resp_msg = mk_resp(8'hC3, 32'hAAAA_0003);
        m_resp_val = 1'b1;
        #1;
        check("bp_first_accept", 192'(m_resp_rdy), 192'(1));
        resp_q.push_back('{port: 3, msg: mk_resp(8'h03, 32'hAAAA_0003)});
        tick();
        m_resp_msg = mk_resp(8'h47, 32'hBBBB_0001);
        resp_q.push_back('{port: 1, msg: mk_resp(8'h07, 32'hBBBB_0001)});
        for (int k = 0; k < 3; k++) begin
            #1;
            check("bp_stall_rdy", 192'(m_resp_rdy), 192'(0));
            check("bp_stall_val", 192'(c_resp_val), 192'(4'b1000));
            tick();
        end
        c_resp_rdy = 4'hF;
        #1;
        check("bp_release_rdy", 192'(m_resp_rdy), 192'(1));
        tick();
        m_resp_val = 1'b0;
        #1;
        check("bp_second_val", 192'(c_resp_val), 192'(4'b0010));
        tick();
        drain("bp");

        // Reset with FIFO full and response register occupied
        m_req_rdy    = 1'b0;
        c_req_msg[1] = mk_req(32'h4100, 8'h31);
        c_req_msg[2] = mk_req(32'h4200, 8'h32);
        c_req_val    = 4'b0110;
        for (int k = 0; k < 2; k++) begin
            #1;
            g = rr_pick(model_ptr, c_req_val);
            check("mid_fill_grant", 192'(c_req_rdy), 192'(1 << g));
            model_ptr = (g + 1) % 4;
            if (k == 1) begin
                c_resp_rdy = 4'h0;
                m_resp_msg = mk_resp(8'h09, 32'hDEAD_0000);
                m_resp_val = 1'b1;
            end
            tick();
        end
        c_req_val  = 4'h0;
        m_resp_val = 1'b0;
        #1;
        check("mid_pre_mem_val", 192'(m_req_val), 192'(1));
        check("mid_pre_resp_val", 192'(c_resp_val), 192'(4'b0001));
        reset     = 1'b0;
        c_req_val = 4'hF;
        #1;
        check("mid_rst_mem_val", 192'(m_req_val), 192'(0));
        check("mid_rst_resp_val", 192'(c_resp_val), 192'(0));
        check("mid_rst_req_rdy", 192'(c_req_rdy), 192'(0));
        check("mid_rst_mem_resp_rdy", 192'(m_resp_rdy), 192'(0));
        c_req_val  = 4'h0;
        c_resp_rdy = 4'hF;
        m_req_rdy  = 1'b1;
        model_ptr  = 0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (3) tick();
        check("mid_post_mem_val", 192'(m_req_val), 192'(0));
        check("mid_post_resp_val", 192'(c_resp_val), 192'(0));
        for (int p = 0; p < 4; p++) c_req_msg[p] = mk_req(32'h5000 + 32'(p * 16), 8'(p + 8'h20));
        c_req_val = 4'hF;
        #1;
        g = rr_pick(model_ptr, c_req_val);
        check("mid_ptr_reset_grant", 192'(c_req_rdy), 192'(1 << g));
        req_q.push_back(tag_req(c_req_msg[g], g));
        model_ptr = (g + 1) % 4;
        tick();
        c_req_val = 4'h0;
        drain("mid");

`ifdef LAB4_SYS_MEM_NET_STATS_EN
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        model_ptr = 0;
        for (int k = 0; k < 5; k++) send_req(0, 32'h6000 + 32'(k * 16), 8'(k));
        for (int k = 0; k < 3; k++) send_req(3, 32'h7000 + 32'(k * 16), 8'(k + 8));
        drain("stats");
        check("stats_port0", 192'(req_count[0]), 192'(5));
        check("stats_port1", 192'(req_count[1]), 192'(0));
        check("stats_port2", 192'(req_count[2]), 192'(0));
        check("stats_port3", 192'(req_count[3]), 192'(3));
`else
        send_req(1, 32'h6100, 8'h3F);
        drain("tail");
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/lab4_sys_mem_net_rr.md
Name: lab4_sys_mem_net_rr

Overview:
- Four-port memory network between the four per-core 16B caches (upstream) and a single 16B memory port (downstream).
- Requests: round-robin arbitration into a 2-entry request FIFO. Each request's source core ID is tagged into the opaque field.
- Responses: buffered in a 1-entry register and steered back to the owning cache by that tag.
- Drop-in implementation of the instruction-memory network in the multi-core system.

Parameters:
- p_num_ports, 4, number of cache ports; the design is fixed at 4, and other values are unsupported.
- p_req_fifo_depth, 2, request FIFO entries; only 2 is supported.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cache2net_reqstream_msg  in  mem_req_16B_t[4]  per-cache request
- cache2net_reqstream_val  in  1[4]  request valid
- cache2net_reqstream_rdy  out  1[4]  request accepted this cycle
- cache2net_respstream_msg  out  mem_resp_16B_t[4]  per-cache response
- cache2net_respstream_val  out  1[4]  response valid
- cache2net_respstream_rdy  in  1[4]  cache accepts response
- net2mem_reqstream_msg  out  mem_req_16B_t  request to memory
- net2mem_reqstream_val  out  1  request valid
- net2mem_reqstream_rdy  in  1  memory accepts request
- net2mem_respstream_msg  in  mem_resp_16B_t  response from memory
- net2mem_respstream_val  in  1  response valid
- net2mem_respstream_rdy  out  1  network accepts response

Behaviour:
- Reset (reset==0, asynchronous):
  - FIFO emptied; response register emptied; priority pointer = 0.
  - Outputs while reset is asserted: net2mem_reqstream_val=0, all cache2net_respstream_val=0, all cache2net_reqstream_rdy=0, net2mem_respstream_rdy=0.
  - In-flight messages are discarded.
  - One cycle after deassertion, net2mem_respstream_rdy=1.
- Handshakes: val/rdy on every stream; a transfer occurs when val&rdy at the clk posedge. rdy must not depend combinationally on the same port's val, except the request grant described below.
- Request arbitration:
  - No grant while the FIFO is full (count==2); all reqstream_rdy=0.
  - Otherwise grant the first valid port searching ptr, ptr+1, ... mod 4.
  - cache2net_reqstream_rdy[g]=1 only for the granted port g; at most one grant per cycle.
  - On a grant, ptr <= (g+1) mod 4. ptr is unchanged when there is no grant.
- Tagging: the enqueued message equals the input except opaque = {g[1:0], in.opaque[5:0]}. Caches must issue opaque < 64.
- Request FIFO:
  - net2mem_reqstream_val = (count!=0); msg = head entry.
  - Enqueue and dequeue in the same cycle are both allowed when count==1.
  - No bypass: minimum latency is accept at cycle N, visible at net2mem at cycle N+1.
  - Order is preserved.
- Response path:
  - net2mem_respstream_rdy = !full_r || cache2net_respstream_rdy[dest_r].
  - On accept: register msg and set dest_r = msg.opaque[7:6], full_r=1.
  - cache2net_respstream_val[d] = full_r && (dest_r==d). Msg is broadcast to all ports with opaque[7:6] cleared to 0.
  - Register clears on downstream handshake unless refilled in the same cycle (back-to-back responses sustain 1 per cycle).
  - Latency: 1 cycle.
- Response ordering follows memory return order; the network does not reorder.
- A stalled destination cache blocks all responses; no per-port buffering.

Optional Feature:
- LAB4_SYS_MEM_NET_STATS_EN defined: adds output ports req_count[4] (32 bits each).
  - Each counter increments by 1 on every accepted request from its port and wraps at 2^32.
  - Counters clear on reset.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single request: port 2 sends read addr 0x1000, opaque 0x05.
  - Expected: net2mem msg appears next cycle with opaque 0x85.
  - Memory responds with opaque 0x85: cache2net_respstream_val[2]=1 one cycle later with opaque 0x05; other ports' val=0.
- Round robin: all 4 ports valid continuously, memory always ready.
  - Expected: grants in order 0,1,2,3,0,1..., one per cycle, full throughput.
- Full FIFO: net2mem_reqstream_rdy=0, ports 0 and 1 valid.
  - Expected: two accepts (ports 0, then 1), then all reqstream_rdy=0. Raise memory rdy: entries drain in order 0x00-tag, 0x40-tag.
- Response backpressure: responses tagged for ports 3 then 1; hold cache2net_respstream_rdy[3]=0 for 3 cycles.
  - Expected: net2mem_respstream_rdy=0 during the stall; port 1's response is delivered after port 3's.
- Reset mid-operation: assert reset with FIFO count=2 and response register full.
  - Expected: all val outputs drop immediately (asynchronous). After release: ptr=0, FIFO empty, no stale message is delivered.
- With LAB4_SYS_MEM_NET_STATS_EN: 5 requests from port 0 and 3 from port 3.
  - Expected: req_count = {5,0,0,3}.
